// File: rtl/tlul_sram_adapter.sv
// TL-UL types shared with the AHB-to-TL-UL bridge, followed by the TL-UL device
// that fronts a single-port synchronous SRAM.
package tlul_pkg;
  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_m2s_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_s2m_t;
endpackage

module tlul_sram_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned SramAw      = 10,
  parameter int unsigned Outstanding = 2,
  parameter int unsigned ReadLatency = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_m2s_t           tl_i,
  output tl_s2m_t           tl_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [TL_DW-1:0]  sram_wdata_o,
  output logic [TL_DW-1:0]  sram_wmask_o,
  input  logic [TL_DW-1:0]  sram_rdata_i
);

  localparam int unsigned CW = $clog2(Outstanding + 1);
  localparam int unsigned PW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam logic [CW:0]   OutLimit = (CW + 1)'(Outstanding);
  localparam logic [PW-1:0] PtrLast  = PW'(Outstanding - 1);

  typedef struct packed {
    logic              valid;
    logic              is_get;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic              err;
  } meta_t;

  typedef struct packed {
    logic              is_data;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic              err;
    logic [TL_DW-1:0]  data;
  } rsp_t;

  logic            a_ready_q;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]   infl_cnt_q, infl_cnt_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  meta_t           meta_q [ReadLatency];
  meta_t           meta_in;
  rsp_t            fifo_q [Outstanding];
  rsp_t            rsp_in;
  rsp_t            head;
  logic            hs, a_err, push, pop, d_valid;
  logic [TL_DBW-1:0] lanes;
  logic            op_ok, size_ok, align_ok, mask_ok, full_ok, range_ok;

  assign hs = tl_i.a_valid & a_ready_q;

  // Request legality: opcode, size, alignment, lane mask and device range.
  always_comb begin
    lanes    = '0;
    align_ok = 1'b0;
    op_ok    = (tl_i.a_opcode == Get) || (tl_i.a_opcode == PutFullData) ||
               (tl_i.a_opcode == PutPartialData);
    size_ok  = (tl_i.a_size <= 2'd2);
    case (tl_i.a_size)
      2'd0: begin
        lanes    = 4'b0001 << tl_i.a_address[1:0];
        align_ok = 1'b1;
      end
      2'd1: begin
        lanes    = 4'b0011 << {tl_i.a_address[1], 1'b0};
        align_ok = ~tl_i.a_address[0];
      end
      2'd2: begin
        lanes    = 4'b1111;
        align_ok = (tl_i.a_address[1:0] == 2'b00);
      end
      default: begin
        lanes    = '0;
        align_ok = 1'b0;
      end
    endcase
    mask_ok  = ((tl_i.a_mask & ~lanes) == '0);
    full_ok  = (tl_i.a_opcode != PutFullData) || (tl_i.a_mask == lanes);
    range_ok = ((tl_i.a_address >> (SramAw + 2)) == '0);
    a_err    = ~(op_ok & size_ok & align_ok & mask_ok & full_ok & range_ok);
  end

  // SRAM strobe straight from the handshake; data path is a pure rewiring of A.
  always_comb begin
    sram_req_o   = hs & ~a_err;
    sram_we_o    = (tl_i.a_opcode != Get);
    sram_addr_o  = tl_i.a_address[SramAw+1:2];
    sram_wdata_o = tl_i.a_data;
    for (int unsigned b = 0; b < TL_DBW; b++) begin
      sram_wmask_o[8*b +: 8] = {8{tl_i.a_mask[b]}};
    end
  end

  // Metadata entering the latency-matching pipeline.
  always_comb begin
    meta_in        = '0;
    meta_in.valid  = hs;
    meta_in.is_get = (tl_i.a_opcode == Get);
    meta_in.size   = tl_i.a_size;
    meta_in.source = tl_i.a_source;
    meta_in.err    = a_err;
  end

  // Shift metadata alongside the SRAM read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ReadLatency; i++) meta_q[i] <= '0;
    end else begin
      meta_q[0] <= meta_in;
      for (int unsigned i = 1; i < ReadLatency; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  assign push    = meta_q[ReadLatency-1].valid;
  assign head    = fifo_q[rptr_q];
  assign d_valid = (fifo_cnt_q != '0);
  assign pop     = d_valid & tl_i.d_ready;

  // Response captured as the matching read data arrives.
  always_comb begin
    rsp_in         = '0;
    rsp_in.is_data = meta_q[ReadLatency-1].is_get;
    rsp_in.size    = meta_q[ReadLatency-1].size;
    rsp_in.source  = meta_q[ReadLatency-1].source;
    rsp_in.err     = meta_q[ReadLatency-1].err;
    rsp_in.data    = (meta_q[ReadLatency-1].is_get && !meta_q[ReadLatency-1].err) ?
                     sram_rdata_i : '0;
  end

  // Occupancy bookkeeping for the FIFO and the in-flight pipeline.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    infl_cnt_d = infl_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - CW'(1);
    if (hs && !push)       infl_cnt_d = infl_cnt_q + CW'(1);
    else if (push && !hs)  infl_cnt_d = infl_cnt_q - CW'(1);
  end

  // a_ready is registered from next-state occupancy, so it equals the
  // register-only compare after reset while staying low during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt_q <= '0;
      infl_cnt_q <= '0;
      a_ready_q  <= 1'b0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      infl_cnt_q <= infl_cnt_d;
      a_ready_q  <= (({1'b0, fifo_cnt_d} + {1'b0, infl_cnt_d}) < OutLimit);
    end
  end

  // Response FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Outstanding; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= rsp_in;
        wptr_q         <= (wptr_q == PtrLast) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PW'(1);
      end
    end
  end

  // D channel driven from the FIFO head.
  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready_q;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = head.is_data ? AccessAckData : AccessAck;
    tl_o.d_param  = '0;
    tl_o.d_size   = head.size;
    tl_o.d_source = head.source;
    tl_o.d_sink   = '0;
    tl_o.d_data   = head.data;
    tl_o.d_error  = head.err;
  end

endmodule

// File: tb/tb_tlul_sram_adapter.sv
// Directed bench for tlul_sram_adapter with default parameters
// (SramAw=10, Outstanding=2, ReadLatency=1) and a behavioural SRAM.
module tb_tlul_sram_adapter;
  import tlul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  tl_m2s_t     tl_i;
  tl_s2m_t     tl_o;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_wmask_o;
  logic [31:0] sram_rdata_i = '0;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [31:0] mem [1024];

  tlul_sram_adapter #(.SramAw(10), .Outstanding(2), .ReadLatency(1)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tl_i         (tl_i),
    .tl_o         (tl_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_wmask_o (sram_wmask_o),
    .sram_rdata_i (sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Single-port SRAM with one cycle of read latency.
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) mem[sram_addr_o] <= (mem[sram_addr_o] & ~sram_wmask_o) |
                                         (sram_wdata_o & sram_wmask_o);
      else           sram_rdata_i <= mem[sram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request with d_ready high: checks the SRAM strobe in the accepting
  // cycle N, no beat at N+1, and the full beat at N+2.
  task automatic do_req(input string tag, input logic [2:0] op, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [7:0] src,
                        input logic exp_req, input logic [31:0] exp_wmask,
                        input logic [2:0] exp_dop, input logic exp_err,
                        input logic [31:0] exp_data);
    @(negedge clk_i);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_size    = sz;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
    tl_i.d_ready   = 1'b1;
    #1;
    check({tag, ".a_ready"}, 64'(tl_o.a_ready), 64'd1);
    check({tag, ".req"}, 64'(sram_req_o), 64'(exp_req));
    check({tag, ".wmask"}, 64'(sram_wmask_o), 64'(exp_wmask));
    if (exp_req) begin
      check({tag, ".we"}, 64'(sram_we_o), 64'(op != Get));
      check({tag, ".addr"}, 64'(sram_addr_o), 64'(addr[11:2]));
    end
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    #1;
    check({tag, ".dv_n1"}, 64'(tl_o.d_valid), 64'd0);
    @(negedge clk_i);
    #1;
    check({tag, ".dv_n2"}, 64'(tl_o.d_valid), 64'd1);
    check({tag, ".dop"}, 64'(tl_o.d_opcode), 64'(exp_dop));
    check({tag, ".derr"}, 64'(tl_o.d_error), 64'(exp_err));
    check({tag, ".ddata"}, 64'(tl_o.d_data), 64'(exp_data));
    check({tag, ".dsrc"}, 64'(tl_o.d_source), 64'(src));
    check({tag, ".dsize"}, 64'(tl_o.d_size), 64'(sz));
  endtask

  initial begin
    logic [7:0] exp_src [3];
    int unsigned idx;
    logic acc;

    tl_i   = '0;
    tl_i.d_ready = 1'b1;
    rst_ni = 1'b0;
    #1;
    check("rst.a_ready", 64'(tl_o.a_ready), 64'd0);
    check("rst.d_valid", 64'(tl_o.d_valid), 64'd0);
    check("rst.req", 64'(sram_req_o), 64'd0);
    check("rst.tl_o", 64'(tl_o == '0), 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Write then read back.
    do_req("put_full", PutFullData, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 8'd1,
           1'b1, 32'hFFFFFFFF, AccessAck, 1'b0, 32'h0);
    do_req("get_full", Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'd2,
           1'b1, 32'hFFFFFFFF, AccessAckData, 1'b0, 32'hDEADBEEF);
    // Byte 1 of word 0x10 lives at byte address 0x11 (lane 1).
    do_req("put_part", PutPartialData, 2'd0, 32'h11, 4'h2, 32'h0000AA00, 8'd3,
           1'b1, 32'h0000FF00, AccessAck, 1'b0, 32'h0);
    do_req("get_part", Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'd4,
           1'b1, 32'hFFFFFFFF, AccessAckData, 1'b0, 32'hDEADAAEF);
    do_req("get_half", Get, 2'd1, 32'h12, 4'hC, 32'h0, 8'd5,
           1'b1, 32'hFFFF0000, AccessAckData, 1'b0, 32'hDEADAAEF);

    // Error cases: no SRAM access, d_error set, data zero.
    do_req("e_align", Get, 2'd2, 32'h11, 4'hF, 32'h0, 8'd6,
           1'b0, 32'hFFFFFFFF, AccessAckData, 1'b1, 32'h0);
    do_req("e_range", Get, 2'd2, 32'h1000, 4'hF, 32'h0, 8'd7,
           1'b0, 32'hFFFFFFFF, AccessAckData, 1'b1, 32'h0);
    do_req("e_opc", 3'd7, 2'd2, 32'h10, 4'hF, 32'h0, 8'd8,
           1'b0, 32'hFFFFFFFF, AccessAck, 1'b1, 32'h0);
    do_req("e_full", PutFullData, 2'd2, 32'h10, 4'h7, 32'h11111111, 8'd9,
           1'b0, 32'h00FFFFFF, AccessAck, 1'b1, 32'h0);
    do_req("e_size", Get, 2'd3, 32'h10, 4'hF, 32'h0, 8'd10,
           1'b0, 32'hFFFFFFFF, AccessAckData, 1'b1, 32'h0);
    do_req("e_lane", Get, 2'd1, 32'h12, 4'h3, 32'h0, 8'd11,
           1'b0, 32'h0000FFFF, AccessAckData, 1'b1, 32'h0);

    // Highest word in range.
    do_req("put_top", PutFullData, 2'd2, 32'hFFC, 4'hF, 32'h12345678, 8'd12,
           1'b1, 32'hFFFFFFFF, AccessAck, 1'b0, 32'h0);
    do_req("get_top", Get, 2'd2, 32'hFFC, 4'hF, 32'h0, 8'd13,
           1'b1, 32'hFFFFFFFF, AccessAckData, 1'b0, 32'h12345678);

    // Backpressure: three back-to-back Gets with d_ready low.
    exp_src[0] = 8'd40; exp_src[1] = 8'd41; exp_src[2] = 8'd42;
    @(negedge clk_i);
    tl_i.d_ready   = 1'b0;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = Get;
    tl_i.a_size    = 2'd2;
    tl_i.a_address = 32'hFFC;
    tl_i.a_mask    = 4'hF;
    tl_i.a_source  = exp_src[0];
    #1 check("bp.acc0", 64'(tl_o.a_ready), 64'd1);
    @(negedge clk_i);
    tl_i.a_source = exp_src[1];
    #1 check("bp.acc1", 64'(tl_o.a_ready), 64'd1);
    @(negedge clk_i);
    tl_i.a_source = exp_src[2];
    #1 check("bp.full", 64'(tl_o.a_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      check("bp.hold_ardy", 64'(tl_o.a_ready), 64'd0);
      check("bp.hold_dv", 64'(tl_o.d_valid), 64'd1);
      check("bp.hold_src", 64'(tl_o.d_source), 64'(exp_src[0]));
      check("bp.hold_data", 64'(tl_o.d_data), 64'h12345678);
    end
    @(negedge clk_i);
    tl_i.d_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      #1;
      acc = tl_i.a_valid & tl_o.a_ready;
      if (tl_o.d_valid) begin
        check("bp.order_src", 64'(tl_o.d_source), 64'(exp_src[idx]));
        check("bp.order_data", 64'(tl_o.d_data), 64'h12345678);
        idx++;
      end
      @(negedge clk_i);
      if (acc) tl_i.a_valid = 1'b0;
    end
    check("bp.count", 64'(idx), 64'd3);
    tl_i.a_valid = 1'b0;

    // Reset with two requests outstanding.
    @(negedge clk_i);
    tl_i.d_ready   = 1'b0;
    tl_i.a_valid   = 1'b1;
    tl_i.a_source  = 8'd20;
    @(negedge clk_i);
    tl_i.a_source  = 8'd21;
    @(negedge clk_i);
    tl_i.a_valid   = 1'b0;
    @(negedge clk_i);
    #1 check("rs.pre_dv", 64'(tl_o.d_valid), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("rs.dv", 64'(tl_o.d_valid), 64'd0);
    check("rs.ardy", 64'(tl_o.a_ready), 64'd0);
    @(negedge clk_i);
    #1;
    check("rs.dv2", 64'(tl_o.d_valid), 64'd0);
    check("rs.ardy2", 64'(tl_o.a_ready), 64'd0);
    rst_ni = 1'b1;
    tl_i.d_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      #1 check("rs.no_stale", 64'(tl_o.d_valid), 64'd0);
    end
    do_req("rs.get", Get, 2'd2, 32'hFFC, 4'hF, 32'h0, 8'd30,
           1'b1, 32'hFFFFFFFF, AccessAckData, 1'b0, 32'h12345678);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
